// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and the letter-code to ASCII helper for the LCD text writer.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC_SET   = 8'h38;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
    localparam logic [7:0] CMD_DISP_BLINK = 8'h0F;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_ENTRY      = 8'h06;
    localparam logic [7:0] CMD_LINE1      = 8'h80;
    localparam logic [7:0] CMD_CURSOR_END = 8'h88;

    localparam logic [4:0] CODE_SPACE  = 5'd31;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_UNK   = 8'h3F;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_LATCH,
        ST_ADDR,
        ST_CHAR,
        ST_CURSOR,
        ST_IDLE
    } lcd_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_STROBE,
        TX_WAIT,
        TX_DONE
    } txn_state_e;

    function automatic logic [7:0] code_to_ascii(input logic [4:0] code);
        if (code <= 5'd25) begin
            return ASCII_A + {3'b000, code};
        end else if (code == CODE_SPACE) begin
            return ASCII_SPACE;
        end else begin
            return ASCII_UNK;
        end
    endfunction

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_bus_txn.sv
// One HD44780 write transaction: setup, enable strobe, then post-strobe wait, ending in a done pulse.
module lcd_bus_txn
    import lcd_pkg::*;
#(
    parameter int EN_PULSE_CYC   = 25,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000,
    parameter int CNT_W          = 17
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [7:0] data_i,
    input  logic       long_i,
    output logic       rs_o,
    output logic [7:0] data_o,
    output logic       en_o,
    output logic       done_o
);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(EN_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);

    txn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] wait_last;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             long_q, long_d;
    logic             en_q, en_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            long_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            long_q  <= long_d;
            en_q    <= en_d;
        end
    end

    // RS/DATA are captured only on an accepted start, so the bus is frozen until done.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rs_d      = rs_q;
        data_d    = data_q;
        long_d    = long_q;
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        wait_last = long_q ? CLEAR_LAST : CMD_LAST;

        case (state_q)
            TX_IDLE: begin
                if (start_i) begin
                    rs_d    = rs_i;
                    data_d  = data_i;
                    long_d  = long_i;
                    cnt_d   = '0;
                    state_d = TX_SETUP;
                end
            end
            TX_SETUP: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = TX_STROBE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            TX_STROBE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = TX_WAIT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            TX_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d   = '0;
                    state_d = TX_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            TX_DONE: begin
                state_d = TX_IDLE;
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase

        en_d = (state_d == TX_STROBE);
    end

    assign rs_o   = rs_q;
    assign data_o = data_q;
    assign en_o   = en_q;
    assign done_o = (state_q == TX_DONE);

endmodule

// File: rtl/lcd_text_writer.sv
// Drives a 16x2 HD44780 LCD from the 8-slot Morse display buffer, rewriting line 1 on every change.
// Optional macro LCD_CURSOR_BLINK_EN: blinking cursor, parked after slot 7 at the end of each frame.
module lcd_text_writer
    import lcd_pkg::*;
#(
    parameter int POWERUP_WAIT_CYC = 750000,
    parameter int EN_PULSE_CYC     = 25,
    parameter int CMD_WAIT_CYC     = 2500,
    parameter int CLEAR_WAIT_CYC   = 100000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [39:0] iDisplayData,
    output logic [7:0]  oLCD_DATA,
    output logic        oLCD_RS,
    output logic        oLCD_RW,
    output logic        oLCD_EN,
    output logic        oLCD_ON,
    output logic        oReady
);

    localparam int CNT_MAX = max_of4(POWERUP_WAIT_CYC, EN_PULSE_CYC, CMD_WAIT_CYC, CLEAR_WAIT_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_WAIT_CYC - 1);

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] DISP_CTRL = CMD_DISP_BLINK;
`else
    localparam logic [7:0] DISP_CTRL = CMD_DISP_ON;
`endif

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] pwr_cnt_q, pwr_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             pending_q, pending_d;
    logic [39:0]      snap_q, snap_d;
    logic [39:0]      shadow_q, shadow_d;

    logic             txn_start;
    logic             txn_rs;
    logic [7:0]       txn_data;
    logic             txn_long;
    logic             txn_done;
    logic             issue;
    logic [4:0]       slot_code;
    logic [7:0]       init_byte;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= ST_PWRUP;
            pwr_cnt_q <= '0;
            idx_q     <= 3'd0;
            pending_q <= 1'b0;
            snap_q    <= 40'hFF_FFFF_FFFF;
            shadow_q  <= 40'hFF_FFFF_FFFF;
        end else begin
            state_q   <= state_d;
            pwr_cnt_q <= pwr_cnt_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            snap_q    <= snap_d;
            shadow_q  <= shadow_d;
        end
    end

    always_comb begin
        slot_code = snap_q[39 -: 5];
        for (int k = 0; k < 8; k++) begin
            if (idx_q == 3'(k)) begin
                slot_code = snap_q[39 - 5*k -: 5];
            end
        end
    end

    always_comb begin
        case (idx_q[1:0])
            2'd0:    init_byte = CMD_FUNC_SET;
            2'd1:    init_byte = DISP_CTRL;
            2'd2:    init_byte = CMD_CLEAR;
            default: init_byte = CMD_ENTRY;
        endcase
    end

    // Each bus-driving state launches one transaction, then advances on its done pulse.
    always_comb begin
        state_d   = state_q;
        pwr_cnt_d = pwr_cnt_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        snap_d    = snap_q;
        shadow_d  = shadow_q;
        txn_start = 1'b0;
        txn_rs    = 1'b0;
        txn_data  = 8'h00;
        txn_long  = 1'b0;
        issue     = 1'b0;

        case (state_q)
            ST_PWRUP: begin
                if (pwr_cnt_q == PWR_LAST) begin
                    pwr_cnt_d = '0;
                    idx_d     = 3'd0;
                    state_d   = ST_INIT;
                end else if (pwr_cnt_q != '1) begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            ST_INIT: begin
                issue    = 1'b1;
                txn_data = init_byte;
                txn_long = (idx_q == 3'd2);
                if (txn_done) begin
                    if (idx_q == 3'd3) begin
                        idx_d   = 3'd0;
                        state_d = ST_LATCH;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_LATCH: begin
                snap_d  = iDisplayData;
                state_d = ST_ADDR;
            end
            ST_ADDR: begin
                issue    = 1'b1;
                txn_data = CMD_LINE1;
                if (txn_done) begin
                    idx_d   = 3'd0;
                    state_d = ST_CHAR;
                end
            end
            ST_CHAR: begin
                issue    = 1'b1;
                txn_rs   = 1'b1;
                txn_data = code_to_ascii(slot_code);
                if (txn_done) begin
                    if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
`ifdef LCD_CURSOR_BLINK_EN
                        state_d = ST_CURSOR;
`else
                        shadow_d = snap_q;
                        state_d  = ST_IDLE;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_CURSOR: begin
                issue    = 1'b1;
                txn_data = CMD_CURSOR_END;
                if (txn_done) begin
                    shadow_d = snap_q;
                    state_d  = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (iDisplayData != shadow_q) begin
                    state_d = ST_LATCH;
                end
            end
            default: begin
                state_d = ST_PWRUP;
            end
        endcase

        if (issue) begin
            txn_start = !pending_q;
            if (!pending_q) begin
                pending_d = 1'b1;
            end
            if (txn_done) begin
                pending_d = 1'b0;
            end
        end
    end

    lcd_bus_txn #(
        .EN_PULSE_CYC   (EN_PULSE_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC),
        .CNT_W          (CNT_W)
    ) u_txn (
        .clk_i   (iCLK),
        .rst_ni  (iRST_N),
        .start_i (txn_start),
        .rs_i    (txn_rs),
        .data_i  (txn_data),
        .long_i  (txn_long),
        .rs_o    (oLCD_RS),
        .data_o  (oLCD_DATA),
        .en_o    (oLCD_EN),
        .done_o  (txn_done)
    );

    assign oLCD_RW = 1'b0;
    assign oLCD_ON = 1'b1;
    assign oReady  = (state_q == ST_IDLE) && (iDisplayData == shadow_q);

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer: init, mapping, change detection, mid-frame change, async reset.
module tb_lcd_text_writer;

`ifdef LCD_CURSOR_BLINK_EN
    localparam int FRAME_LEN = 10;
    localparam logic [7:0] EXP_CTRL = 8'h0F;
`else
    localparam int FRAME_LEN = 9;
    localparam logic [7:0] EXP_CTRL = 8'h0C;
`endif

    logic        clk;
    logic        rst_n;
    logic [39:0] dispData;
    logic [7:0]  lcdData;
    logic        lcdRs;
    logic        lcdRw;
    logic        lcdEn;
    logic        lcdOn;
    logic        ready;

    int checks;
    int errors;
    int cyc;

    logic [8:0] txq[$];
    int         riseq[$];
    int         fallq[$];
    int         widthq[$];
    int         stableViol;
    logic       enPrev;
    int         hiCnt;
    logic [8:0] curTxn;

    logic [8:0] exp[$];

    lcd_text_writer #(
        .POWERUP_WAIT_CYC (20),
        .EN_PULSE_CYC     (2),
        .CMD_WAIT_CYC     (5),
        .CLEAR_WAIT_CYC   (12)
    ) dut (
        .iCLK         (clk),
        .iRST_N       (rst_n),
        .iDisplayData (dispData),
        .oLCD_DATA    (lcdData),
        .oLCD_RS      (lcdRs),
        .oLCD_RW      (lcdRw),
        .oLCD_EN      (lcdEn),
        .oLCD_ON      (lcdOn),
        .oReady       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: logs each EN rise with its RS/DATA, its high width and any bus change while high.
    initial begin
        enPrev     = 1'b0;
        hiCnt      = 0;
        stableViol = 0;
        curTxn     = 9'h000;
    end
    always @(negedge clk) begin
        if (!enPrev && lcdEn) begin
            curTxn = {lcdRs, lcdData};
            txq.push_back(curTxn);
            riseq.push_back(cyc);
            hiCnt = 1;
        end else if (lcdEn) begin
            hiCnt++;
            if ({lcdRs, lcdData} !== curTxn) stableViol++;
        end
        if (enPrev && !lcdEn) begin
            widthq.push_back(hiCnt);
            fallq.push_back(cyc);
        end
        enPrev = lcdEn;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_log();
        txq.delete();
        riseq.delete();
        fallq.delete();
        widthq.delete();
        stableViol = 0;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_txns(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (txq.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_frame_tail();
`ifdef LCD_CURSOR_BLINK_EN
        exp.push_back({1'b0, 8'h88});
`endif
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        dispData = 40'hFF_FFFF_FFFF;
        repeat (3) @(negedge clk);
        checks++; if (lcdData !== 8'h00) begin errors++; $display("[TB] FAIL reset_data actual=%h required=00", lcdData); end
        checks++; if (lcdRs !== 1'b0) begin errors++; $display("[TB] FAIL reset_rs actual=%b required=0", lcdRs); end
        checks++; if (lcdRw !== 1'b0) begin errors++; $display("[TB] FAIL reset_rw actual=%b required=0", lcdRw); end
        checks++; if (lcdEn !== 1'b0) begin errors++; $display("[TB] FAIL reset_en actual=%b required=0", lcdEn); end
        checks++; if (lcdOn !== 1'b1) begin errors++; $display("[TB] FAIL reset_on actual=%b required=1", lcdOn); end
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready actual=%b required=0", ready); end
    endtask

    task automatic run_init_and_check(input string tag);
        bit ok;
        int rel;
        int gapCmd;
        int gapClr;
        clear_log();
        @(negedge clk);
        rel   = cyc;
        rst_n = 1'b1;
        wait_ready(3000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL %s_ready_timeout actual=%b required=1", tag, ready); end

        exp.delete();
        exp.push_back({1'b0, 8'h38});
        exp.push_back({1'b0, EXP_CTRL});
        exp.push_back({1'b0, 8'h01});
        exp.push_back({1'b0, 8'h06});
        exp.push_back({1'b0, 8'h80});
        for (int i = 0; i < 8; i++) exp.push_back({1'b1, 8'h20});
        push_frame_tail();

        checks++; if (txq.size() != exp.size()) begin errors++; $display("[TB] FAIL %s_count actual=%0d required=%0d", tag, txq.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== exp[i]) begin errors++; $display("[TB] FAIL %s_txn%0d actual=%h required=%h", tag, i, txq[i], exp[i]); end
        end
        for (int i = 0; i < widthq.size(); i++) begin
            checks++;
            if (widthq[i] != 2) begin errors++; $display("[TB] FAIL %s_en_width%0d actual=%0d required=2", tag, i, widthq[i]); end
        end
        if (riseq.size() > 0) begin
            checks++;
            if (riseq[0] - rel < 20 || riseq[0] - rel > 30) begin
                errors++; $display("[TB] FAIL %s_powerup_wait actual=%0d required=20..30", tag, riseq[0] - rel);
            end
        end
        if (riseq.size() > 3 && fallq.size() > 2) begin
            gapCmd = riseq[1] - fallq[0];
            gapClr = riseq[3] - fallq[2];
            // Clear waits 12 cycles instead of 5, so its idle gap is exactly 7 cycles longer.
            checks++;
            if (gapClr - gapCmd != 7) begin errors++; $display("[TB] FAIL %s_clear_gap actual=%0d required=7", tag, gapClr - gapCmd); end
        end
        checks++; if (stableViol != 0) begin errors++; $display("[TB] FAIL %s_bus_stable actual=%0d required=0", tag, stableViol); end
    endtask

    task automatic test_init();
        run_init_and_check("init");
    endtask

    task automatic test_change_detect();
        bit ok;
        int n0;
        clear_log();
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL chg_ready_before actual=%b required=1", ready); end
        dispData = 40'hFF_FFFF_FFE0;
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL chg_ready_fall actual=%b required=0", ready); end
        wait_ready(1000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL chg_ready_timeout actual=%b required=1", ready); end
        exp.delete();
        exp.push_back({1'b0, 8'h80});
        for (int i = 0; i < 7; i++) exp.push_back({1'b1, 8'h20});
        exp.push_back({1'b1, 8'h41});
        push_frame_tail();
        checks++; if (txq.size() != FRAME_LEN) begin errors++; $display("[TB] FAIL chg_count actual=%0d required=%0d", txq.size(), FRAME_LEN); end
        for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== exp[i]) begin errors++; $display("[TB] FAIL chg_txn%0d actual=%h required=%h", i, txq[i], exp[i]); end
        end
        n0 = txq.size();
        repeat (1000) @(negedge clk);
        checks++; if (txq.size() != n0) begin errors++; $display("[TB] FAIL chg_quiet actual=%0d required=%0d", txq.size(), n0); end
    endtask

    task automatic test_mapping();
        bit ok;
        clear_log();
        @(negedge clk);
        dispData = {5'd0, 5'd25, 5'd4, 5'd19, 5'd26, 5'd31, 5'd7, 5'd14};
        wait_ready(1000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL map_ready_timeout actual=%b required=1", ready); end
        exp.delete();
        exp.push_back({1'b0, 8'h80});
        exp.push_back({1'b1, 8'h41});
        exp.push_back({1'b1, 8'h5A});
        exp.push_back({1'b1, 8'h45});
        exp.push_back({1'b1, 8'h54});
        exp.push_back({1'b1, 8'h3F});
        exp.push_back({1'b1, 8'h20});
        exp.push_back({1'b1, 8'h48});
        exp.push_back({1'b1, 8'h4F});
        push_frame_tail();
        checks++; if (txq.size() != exp.size()) begin errors++; $display("[TB] FAIL map_count actual=%0d required=%0d", txq.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== exp[i]) begin errors++; $display("[TB] FAIL map_txn%0d actual=%h required=%h", i, txq[i], exp[i]); end
        end
    endtask

    task automatic test_midframe();
        bit ok;
        clear_log();
        @(negedge clk);
        dispData = {8{5'd2}};
        wait_txns(4, 1000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_third_char_timeout actual=%0d required=4", txq.size()); end
        dispData = {8{5'd22}};
        wait_txns(2 * FRAME_LEN, 2000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_two_frames_timeout actual=%0d required=%0d", txq.size(), 2 * FRAME_LEN); end
        wait_ready(1000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL mid_ready_timeout actual=%b required=1", ready); end
        exp.delete();
        exp.push_back({1'b0, 8'h80});
        for (int i = 0; i < 8; i++) exp.push_back({1'b1, 8'h43});
        push_frame_tail();
        exp.push_back({1'b0, 8'h80});
        for (int i = 0; i < 8; i++) exp.push_back({1'b1, 8'h57});
        push_frame_tail();
        checks++; if (txq.size() != exp.size()) begin errors++; $display("[TB] FAIL mid_count actual=%0d required=%0d", txq.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== exp[i]) begin errors++; $display("[TB] FAIL mid_txn%0d actual=%h required=%h", i, txq[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid_strobe();
        bit ok;
        @(negedge clk);
        dispData = 40'hFF_FFFF_FFFF;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (lcdEn === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rstmid_en_timeout actual=%b required=1", lcdEn); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (lcdEn !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_en_async actual=%b required=0", lcdEn); end
        checks++; if (lcdData !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_data actual=%h required=00", lcdData); end
        checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ready actual=%b required=0", ready); end
        repeat (3) @(negedge clk);
        run_init_and_check("reinit");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_init();
        test_change_detect();
        test_mapping();
        test_midframe();
        test_reset_mid_strobe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_text_writer.md
Name: lcd_text_writer

Overview:
- Downstream consumer of the Morse RX decoder's 40-bit display buffer: 8 slots × 5-bit letter codes.
- Converts each code to ASCII and drives an HD44780-compatible 16x2 character LCD in 8-bit, write-only mode.
- Runs the power-up init sequence, then rewrites line 1 (positions 0-7) whenever the buffer content changes.

Parameters:
- POWERUP_WAIT_CYC, 750000: idle cycles after reset before the first command (15 ms at 50 MHz).
- EN_PULSE_CYC, 25: cycles oLCD_EN is held high per transaction; also used as the setup time before EN rises.
- CMD_WAIT_CYC, 2500: post-strobe wait for normal commands and data writes (50 us).
- CLEAR_WAIT_CYC, 100000: post-strobe wait after Clear Display 0x01 (2 ms).

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous active-low reset.
- iDisplayData  in  40  slot k = bits [39-5k -: 5]; slot 0 (oldest) is shown leftmost; codes 0-25 = A-Z, 31 = space.
- oLCD_DATA  out  8  LCD data bus.
- oLCD_RS  out  1  0 = command, 1 = data.
- oLCD_RW  out  1  tied 0 (write only).
- oLCD_EN  out  1  enable strobe.
- oLCD_ON  out  1  LCD power; constant 1.
- oReady  out  1  high once init is complete and no frame is in progress.

Behaviour:
- Clock and reset:
  - One clock, iCLK.
  - Reset iRST_N is asynchronous, active-low.
- Reset values:
  - oLCD_DATA = 0x00, oLCD_RS = 0, oLCD_RW = 0, oLCD_EN = 0, oLCD_ON = 1, oReady = 0.
  - shadow register = 40'hFF_FFFF_FFFF; all counters = 0.
- Reset mid-operation: oLCD_EN drops immediately (asynchronous) and the sequence restarts at PWRUP.
- Bus transaction (sub-module), triggered by a 1-cycle start:
  - SETUP: RS and DATA are registered and stable; EN = 0 for EN_PULSE_CYC cycles.
  - STROBE: EN = 1 for EN_PULSE_CYC cycles.
  - WAIT: EN = 0 for CMD_WAIT_CYC cycles, or CLEAR_WAIT_CYC when the long flag is set.
  - Then a 1-cycle done pulse.
  - RS and DATA must not change from SETUP entry until done.
  - A start received while busy is ignored.
- Top-level FSM:
  - PWRUP: count POWERUP_WAIT_CYC cycles.
  - INIT: issue in order 0x38 (function set), 0x0C (display control), 0x01 (clear, long wait), 0x06 (entry mode).
  - LATCH: copy iDisplayData into the snapshot.
  - ADDR: issue command 0x80.
  - CHAR: 8 data writes, slots 0→7, from the snapshot.
  - IDLE: oReady = 1.
- FSM transitions:
  - After INIT, go to LATCH unconditionally, so the first frame is always written.
  - After CHAR, the shadow register takes the snapshot, then go to IDLE.
  - IDLE → LATCH on the first cycle where iDisplayData ≠ shadow; oReady falls in that same cycle.
- Code-to-ASCII mapping:
  - 0-25 → 0x41 + code.
  - 31 → 0x20.
  - 26-30 → 0x3F ('?').
- Mid-frame input changes:
  - The frame in progress uses the snapshot and is not restarted.
  - The difference is detected in IDLE immediately afterwards, and a new frame follows.
- Counter widths are sized with $clog2 of the largest wait parameter; counters saturate rather than wrap.

Optional Feature:
- Macro LCD_CURSOR_BLINK_EN.
- Defined:
  - INIT display control is 0x0F (cursor and blink on).
  - Each frame ends with an extra command 0x88, placing the cursor after slot 7 before IDLE.
  - A frame is 10 transactions.
- Undefined:
  - Display control is 0x0C.
  - No trailing address command; a frame is 9 transactions.

Decomposition:
- Shared package lcd_pkg:
  - LCD command constants: CMD_FUNC_SET = 8'h38, CMD_DISP_ON = 8'h0C, CMD_DISP_BLINK = 8'h0F, CMD_CLEAR = 8'h01, CMD_ENTRY = 8'h06, CMD_LINE1 = 8'h80.
  - Letter-code constants: CODE_SPACE = 5'd31, ASCII_A = 8'h41, ASCII_SPACE = 8'h20, ASCII_UNK = 8'h3F.
  - Top FSM state enum.
  - A code-to-ASCII function.
- One sub-module, lcd_bus_txn: the SETUP/STROBE/WAIT timing with start/done handshake.

Test Plan (benches use POWERUP_WAIT_CYC = 20, EN_PULSE_CYC = 2, CMD_WAIT_CYC = 5, CLEAR_WAIT_CYC = 12):
- Init sequence:
  - Stimulus: release iRST_N with iDisplayData = all 1s.
  - Response: no EN edge for 20 cycles; then EN strobes carrying RS=0 bytes 38,0C,01,06,80, then 8 RS=1 bytes of 0x20; oReady rises afterwards.
  - EN high for exactly 2 cycles per strobe; 12-cycle gap after 0x01.
- Mapping:
  - Stimulus: iDisplayData slots 0-7 = {0,25,4,19,26,31,7,14}.
  - Response: data bytes 41,5A,45,54,3F,20,48,4F in that order, each after an 80 command.
- Change detection:
  - Stimulus: in IDLE, change only slot 7 from 31 to 0.
  - Response: oReady falls the same cycle; a full 9-transaction frame follows whose last byte is 0x41. Constant input produces no further strobes for 1000 cycles.
- Mid-frame change:
  - Stimulus: change iDisplayData during the 3rd CHAR write.
  - Response: the current frame completes with the old values; a second frame with the new values follows.
- Reset mid-strobe:
  - Stimulus: assert iRST_N low while oLCD_EN = 1.
  - Response: EN = 0 within the same cycle without waiting for a clock edge; after release the full init sequence repeats.
- Feature build:
  - Stimulus: build with LCD_CURSOR_BLINK_EN defined.
  - Response: the second init command is 0x0F; each frame ends with command 0x88 (10 strobes per frame).
